mdu_unit: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It owns the HI/LO registers.
- Runs MULT/MULTU/DIV/DIVU as multi-cycle operations, with a modelled latency.
- Supplies MFHI/MFLO read data to the E-stage result mux.
- Exports `md_busy`, the upstream input to the hazard/stall unit. The stall unit holds any D-stage md-class instruction while `md_busy` is high.

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_arith.sv | 55 +++++
 rtl/mdu_unit.sv | 87 ++++++++
 tb/tb_mdu_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies, decode helpers.
// MDU_MADD_EN enables the MADD/MADDU accumulate ops.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MFHI    = 4'd5,
        MFLO    = 4'd6,
        MTHI    = 4'd7,
        MTLO    = 4'd8,
        MADD    = 4'd9,
        MADDU   = 4'd10
    } md_op_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_md_start(input logic [3:0] op);
        case (op)
            MULT, MULTU, DIV, DIVU: is_md_start = 1'b1;
`ifdef MDU_MADD_EN
            MADD, MADDU:            is_md_start = 1'b1;
`endif
            default:                is_md_start = 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for the multiply/divide ops.
// MDU_MADD_EN adds the HI/LO accumulate path for MADD/MADDU.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MDU_MADD_EN
    input  logic [63:0] acc,
`endif
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic [31:0] udiv_b, ud_q, ud_r;
    logic [31:0] mag_a, mag_b, sdiv_b, sd_q, sd_r, quot_s, rem_s;

    assign prod_u = {32'b0, a} * {32'b0, b};
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // Divisor forced to 1 on zero so the dividers never see 0; the result is discarded anyway.
    assign udiv_b = (b == 32'd0) ? 32'd1 : b;
    assign ud_q   = a / udiv_b;
    assign ud_r   = a % udiv_b;

    // Signed divide on magnitudes: 0x80000000 / -1 falls out naturally as 0x80000000.
    assign mag_a  = a[31] ? -a : a;
    assign mag_b  = b[31] ? -b : b;
    assign sdiv_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign sd_q   = mag_a / sdiv_b;
    assign sd_r   = mag_a % sdiv_b;
    assign quot_s = (a[31] ^ b[31]) ? -sd_q : sd_q;
    assign rem_s  = a[31] ? -sd_r : sd_r;

    assign div_zero = is_div(op) && (b == 32'd0);

    always_comb begin
        result = '0;
        case (op)
            MULT:    result = prod_s;
            MULTU:   result = prod_u;
            DIV:     result = {rem_s, quot_s};
            DIVU:    result = {ud_r, ud_q};
`ifdef MDU_MADD_EN
            MADD:    result = acc + prod_s;
            MADDU:   result = acc + prod_u;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO, with modelled multi-cycle latency and md_busy for the stall unit.
// MDU_MADD_EN enables MADD/MADDU (accumulate into HI/LO sampled at start).
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic [31:0] E_rs_data,
    input  logic [31:0] E_rt_data,
    output logic        md_start,
    output logic        md_busy,
    output logic [31:0] md_rdata,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [15:0] MULT_N = 16'(MULT_CYCLES);
    localparam logic [15:0] DIV_N  = 16'(DIV_CYCLES);

    logic [31:0] hi, lo, pend_hi, pend_lo;
    logic        pend_wr;
    logic        busy;
    logic [15:0] count;
    logic [63:0] result;
    logic        div_zero;

    mdu_arith u_arith (
        .op       (E_md_op),
        .a        (E_rs_data),
        .b        (E_rt_data),
`ifdef MDU_MADD_EN
        .acc      ({hi, lo}),
`endif
        .result   (result),
        .div_zero (div_zero)
    );

    assign md_start = is_md_start(E_md_op) && !busy;
    assign md_busy  = busy | md_start;
    assign hi_out   = hi;
    assign lo_out   = lo;

    always_comb begin
        md_rdata = 32'd0;
        case (E_md_op)
            MFHI:    md_rdata = hi;
            MFLO:    md_rdata = lo;
            default: md_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            busy    <= 1'b0;
            count   <= 16'd0;
        end else if (busy) begin
            count <= count - 16'd1;
            if (count == 16'd1) begin
                busy <= 1'b0;
                if (pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end else if (md_start) begin
            pend_hi <= result[63:32];
            pend_lo <= result[31:0];
            pend_wr <= ~div_zero;
            count   <= is_div(E_md_op) ? DIV_N : MULT_N;
            busy    <= 1'b1;
        end else if (E_md_op == MTHI) begin
            hi <= E_rs_data;
        end else if (E_md_op == MTLO) begin
            lo <= E_rs_data;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: latency windows, arithmetic results, MT writes, reset abort.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  E_md_op = 4'd0;
    logic [31:0] E_rs_data = 32'd0;
    logic [31:0] E_rt_data = 32'd0;
    logic        md_start, md_busy;
    logic [31:0] md_rdata, hi_out, lo_out;

    int total = 0;
    int passed = 0;
    logic [31:0] cur_hi, cur_lo;

    mdu_unit dut (
        .clk       (clk),
        .reset     (reset),
        .E_md_op   (E_md_op),
        .E_rs_data (E_rs_data),
        .E_rt_data (E_rt_data),
        .md_start  (md_start),
        .md_busy   (md_busy),
        .md_rdata  (md_rdata),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Apply inputs just after a rising edge, return at the following falling edge for sampling.
    task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(posedge clk);
        #1;
        E_md_op   = op;
        E_rs_data = rs;
        E_rt_data = rt;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(MD_NONE, 32'd0, 32'd0);
        drive(MD_NONE, 32'd0, 32'd0);
        reset = 1'b0;
        drive(MFHI, 32'd0, 32'd0);
        total++;
        if (md_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 00000000", md_rdata);
        else passed++;
        total++;
        if (md_busy !== 1'b0 || md_start !== 1'b0)
            $display("FAIL reset_busy: got busy=%b start=%b want 0/0", md_busy, md_start);
        else passed++;
        total++;
        if (hi_out !== 32'd0 || lo_out !== 32'd0)
            $display("FAIL reset_hilo: got %h/%h want 0/0", hi_out, lo_out);
        else passed++;
        cur_hi = 32'd0;
        cur_lo = 32'd0;
    endtask

    // Start an op, probe the busy window (ignored start and MTHI inside it), then check the result.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        bit done;
        drive(op, rs, rt);
        total++;
        if (md_start !== 1'b1 || md_busy !== 1'b1)
            $display("FAIL %s_start: got start=%b busy=%b want 1/1", name, md_start, md_busy);
        else passed++;
        cnt = 0;
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            if (k == 2)      drive(MULT, 32'h5, 32'h6);
            else if (k == 3) drive(MTHI, 32'hDEAD_BEEF, 32'd0);
            else             drive(MFLO, 32'd0, 32'd0);
            if (md_busy === 1'b1) begin
                cnt++;
                if (k == 2) begin
                    total++;
                    if (md_start !== 1'b0) $display("FAIL %s_ignore_start: got %b want 0", name, md_start);
                    else passed++;
                end else if (k != 3) begin
                    total++;
                    if (md_rdata !== cur_lo)
                        $display("FAIL %s_old_lo c%0d: got %h want %h", name, k, md_rdata, cur_lo);
                    else passed++;
                end
            end else begin
                done = 1'b1;
            end
        end
        total++;
        if (cnt !== n) $display("FAIL %s_busy_cycles: got %0d want %0d", name, cnt, n);
        else passed++;
        total++;
        if (hi_out !== exp_hi || lo_out !== exp_lo)
            $display("FAIL %s_result: got hi=%h lo=%h want hi=%h lo=%h", name, hi_out, lo_out, exp_hi, exp_lo);
        else passed++;
        total++;
        if (md_rdata !== exp_lo) $display("FAIL %s_mflo: got %h want %h", name, md_rdata, exp_lo);
        else passed++;
        cur_hi = exp_hi;
        cur_lo = exp_lo;
    endtask

    task automatic test_mt();
        drive(MTHI, 32'h11, 32'd0);
        total++;
        if (md_busy !== 1'b0 || md_start !== 1'b0)
            $display("FAIL mthi_busy: got busy=%b start=%b want 0/0", md_busy, md_start);
        else passed++;
        drive(MTLO, 32'h22, 32'd0);
        total++;
        if (hi_out !== 32'h11) $display("FAIL mthi_write: got %h want 00000011", hi_out);
        else passed++;
        drive(MFHI, 32'd0, 32'd0);
        total++;
        if (lo_out !== 32'h22 || md_rdata !== 32'h11)
            $display("FAIL mtlo_write: got lo=%h rdata=%h want 00000022/00000011", lo_out, md_rdata);
        else passed++;
        cur_hi = 32'h11;
        cur_lo = 32'h22;
    endtask

    task automatic test_invalid_op();
        drive(4'd15, 32'h1, 32'h2);
        total++;
        if (md_start !== 1'b0 || md_busy !== 1'b0 || md_rdata !== 32'd0)
            $display("FAIL invalid_op: got start=%b busy=%b rdata=%h want 0/0/0", md_start, md_busy, md_rdata);
        else passed++;
`ifndef MDU_MADD_EN
        drive(4'd9, 32'h1, 32'h2);
        total++;
        if (md_start !== 1'b0 || md_busy !== 1'b0)
            $display("FAIL madd_disabled: got start=%b busy=%b want 0/0", md_start, md_busy);
        else passed++;
`endif
        drive(MFHI, 32'd0, 32'd0);
        total++;
        if (hi_out !== cur_hi || lo_out !== cur_lo)
            $display("FAIL invalid_no_write: got %h/%h want %h/%h", hi_out, lo_out, cur_hi, cur_lo);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        drive(MULT, 32'h2, 32'h3);
        total++;
        if (md_start !== 1'b1) $display("FAIL abort_start: got %b want 1", md_start);
        else passed++;
        drive(MD_NONE, 32'd0, 32'd0);
        drive(MD_NONE, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (md_busy !== 1'b1) $display("FAIL abort_busy_c3: got %b want 1", md_busy);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (md_busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0)
            $display("FAIL abort_cleared: got busy=%b hi=%h lo=%h want 0/0/0", md_busy, hi_out, lo_out);
        else passed++;
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        run_op("multu_after", MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    endtask

    initial begin
        test_reset();
        run_op("mult",     MULT,  32'hFFFF_FFFF, 32'h2,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("divu",     DIVU,  32'd7,         32'd2,         10, 32'h1,         32'h3);
        run_op("div_neg",  DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0,         32'h8000_0000);
        run_op("multu_big", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        test_mt();
        run_op("div_zero", DIV,   32'h1234,      32'd0,         10, 32'h11,        32'h22);
        test_invalid_op();
        test_reset_mid_op();
`ifdef MDU_MADD_EN
        run_op("madd",     MADD,  32'hFFFF_FFFF, 32'd3,         5,  32'd0,         32'd9);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
